alu_share_arbiter: RTL

Two-requester, round-robin scheduler that time-shares one registered 8-bit ALU (add, xor, and, or) between independent requesters inside the user tile. It sits between the pin-level request sources and the result path: it captures operands, sequences a single ALU operation, then holds the result with a valid/ready handshake until it is consumed. One operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin time-sharing of one registered ALU
// (add/xor/and/or) between two requesters. One operation is in flight at a
// time: capture operands, execute, then hold the result until it is consumed.
module alu_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] res,
    output logic             res_carry,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_capture;
    logic             w_release;
    logic             w_win_id;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_last_id;

    logic             r_gnt0;
    logic             r_gnt1;
    logic [WIDTH-1:0] r_res;
    logic             r_res_carry;
    logic             r_res_id;
    logic             r_res_valid;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, capture/release strobes and round-robin winner.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        // Tie goes to the requester that did not win last; otherwise the
        // single requester (or don't-care when nobody requests).
        w_win_id     = (req0 && req1) ? ~r_last_id : req1;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_capture    = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ALU on the captured operands; carry only meaningful for add.
    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = 1'b0;
        case (r_op)
            OP_ADD:  w_alu_carry = w_sum[WIDTH];
            OP_XOR:  w_alu_res   = r_a ^ r_b;
            OP_AND:  w_alu_res   = r_a & r_b;
            default: w_alu_res   = r_a | r_b;
        endcase
    end

    // Operand capture of the winning requester.
    // NOTE: these registers have no reset; they are only read in EXEC, which
    // is always preceded by a capture, so reset values would be dead logic.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_op <= w_win_id ? op1 : op0;
            r_a  <= w_win_id ? a1  : a0;
            r_b  <= w_win_id ? b1  : b0;
            r_id <= w_win_id;
        end
    end

    // Grant pulses and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_last_id <= 1'b1;
        end else begin
            r_gnt0 <= w_capture && !w_win_id;
            r_gnt1 <= w_capture &&  w_win_id;
            if (w_capture) begin
                r_last_id <= w_win_id;
            end
        end
    end

    // Result registers: loaded in EXEC, valid dropped on handshake, data kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res       <= '0;
            r_res_carry <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (r_state == EXEC) begin
            r_res       <= w_alu_res;
            r_res_carry <= w_alu_carry;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign res       = r_res;
    assign res_carry = r_res_carry;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;
    assign busy      = (r_state != IDLE);

endmodule
